// File: rtl/el_pkg.sv
// EL frame RAM address map and shared types.
// Shared by the scan engine and the frame-buffer writer.
package el_pkg;

    localparam int unsigned X_RES      = 640;
    localparam int unsigned Y_RES      = 200;
    localparam int unsigned ROW_BYTES  = 160;
    localparam int unsigned BUF_B_BASE = 38400;
    localparam int unsigned THRESH     = 128;

    localparam int unsigned AW = 17;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    typedef enum logic [1:0] {
        WAIT_VS,
        ACTIVE,
        DONE
    } el_state_t;

    // Row y of the 2*Y_RES panel folds onto Y_RES RAM rows (two nibble lanes).
    function automatic logic [AW-1:0] el_word(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y,
        input logic          buf_b
    );
        logic [YW-1:0] row;
        row = (y < YW'(Y_RES)) ? y : y - YW'(Y_RES);
        return AW'(x >> 2)
             + AW'(row) * AW'(ROW_BYTES)
             + (buf_b ? AW'(BUF_B_BASE) : '0);
    endfunction

endpackage

// File: rtl/el_nibble_packer.sv
// Thresholds luma to 1 bpp and packs 4 pixels per nibble.
// A flush emits a partial nibble, zero-padded in the low bits.
module el_nibble_packer
    import el_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       valid,
    input  logic [7:0] luma,
    input  logic       flush,
    output logic       nib_valid,
    output logic [3:0] nib
);

    logic [1:0] cnt;
    logic [2:0] sh;
    logic       lit;

    assign lit = (luma >= 8'(THRESH));

    always_comb begin
        nib_valid = 1'b0;
        nib       = 4'h0;
        if (flush && cnt != 2'd0) begin
            nib_valid = 1'b1;
            unique case (cnt)
                2'd1:    nib = {sh[0], 3'b000};
                2'd2:    nib = {sh[1:0], 2'b00};
                default: nib = {sh, 1'b0};
            endcase
        end else if (valid && cnt == 2'd3) begin
            nib_valid = 1'b1;
            nib       = {sh, lit};
        end
    end

    // A pixel arriving with a flush starts a fresh group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            sh  <= 3'b000;
        end else if (en) begin
            if (clr) begin
                cnt <= 2'd0;
                sh  <= 3'b000;
            end else if (flush) begin
                cnt <= valid ? 2'd1 : 2'd0;
                sh  <= {2'b00, valid & lit};
            end else if (valid) begin
                cnt <= cnt + 2'd1;
                sh  <= {sh[1:0], lit};
            end
        end
    end

endmodule

// File: rtl/el_fb_writer.sv
// Video stream to EL frame RAM writer, 1 bpp, ping-pong buffers A/B.
// Upper nibble lane holds rows 0..Y_RES-1, lower lane the rest.
module el_fb_writer
    import el_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [7:0]  vid_luma,
    output logic [16:0] wr_addr,
    output logic [3:0]  wr_data,
    output logic        wr_en_up,
    output logic        wr_en_dn,
    output logic        frame,
    output logic        frame_done,
    output logic        err_short
);

    localparam logic [XW-1:0] XMAX  = XW'(X_RES);
    localparam logic [YW-1:0] YHALF = YW'(Y_RES);
    localparam logic [YW-1:0] YLAST = YW'(2 * Y_RES - 1);

    el_state_t state, state_n;

    logic          vs_q;
    logic          de_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic vs_rise;
    logic de_fall;
    logic clr;
    logic restart;
    logic pix;
    logic flush;

    logic       nib_valid;
    logic [3:0] nib;

    assign vs_rise = vid_vs & ~vs_q;
    assign de_fall = de_q & ~vid_de;

    el_nibble_packer u_pack (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .valid     (pix),
        .luma      (vid_luma),
        .flush     (flush),
        .nib_valid (nib_valid),
        .nib       (nib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_VS;
        end else if (en) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        restart = 1'b0;
        pix     = 1'b0;
        flush   = 1'b0;
        unique case (state)
            WAIT_VS: begin
                if (vs_rise) begin
                    clr     = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    clr     = 1'b1;
                    restart = 1'b1;
                end else begin
                    pix = vid_de && (x < XMAX);
                    if (de_fall) begin
                        flush = 1'b1;
                        if (y == YLAST) begin
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_n = WAIT_VS;
            end
            default: begin
                state_n = WAIT_VS;
            end
        endcase
    end

    // x saturates at X_RES so excess pixels are dropped but still counted as a full line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            x          <= '0;
            y          <= '0;
            wr_addr    <= '0;
            wr_data    <= 4'h0;
            wr_en_up   <= 1'b0;
            wr_en_dn   <= 1'b0;
            frame      <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
        end else if (!en) begin
            wr_en_up   <= 1'b0;
            wr_en_dn   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vs_q       <= vid_vs;
            de_q       <= vid_de;
            wr_en_up   <= nib_valid && (y < YHALF);
            wr_en_dn   <= nib_valid && (y >= YHALF);
            frame_done <= (state == DONE);
            if (nib_valid) begin
                wr_addr <= el_word(x, y, frame);
                wr_data <= nib;
            end
            if (state == DONE) begin
                frame <= ~frame;
            end
            if (restart) begin
                err_short <= 1'b1;
            end
            if (clr) begin
                x <= '0;
                y <= '0;
            end else if (flush) begin
                if (x < XMAX) begin
                    err_short <= 1'b1;
                end
                x <= '0;
                y <= y + YW'(1);
            end else if (pix) begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: tb/tb_el_fb_writer.sv
// Self-checking bench for el_fb_writer: vector table, hand sequences,
// and random lines against a line-level reference model.
module tb_el_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vid_vs;
    logic        vid_de;
    logic [7:0]  vid_luma;
    logic [16:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_en_up;
    logic        wr_en_dn;
    logic        frame;
    logic        frame_done;
    logic        err_short;

    always #5 clk = ~clk;

    el_fb_writer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .vid_vs     (vid_vs),
        .vid_de     (vid_de),
        .vid_luma   (vid_luma),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en_up   (wr_en_up),
        .wr_en_dn   (wr_en_dn),
        .frame      (frame),
        .frame_done (frame_done),
        .err_short  (err_short)
    );

    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  data;
        logic        dn;
    } wr_t;

    typedef struct packed {
        logic [31:0] lum;
        logic [3:0]  nib;
    } tv_t;

    wr_t got[$];
    wr_t exp_q[$];
    logic [7:0] px [0:1023];
    tv_t tv [0:7];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int both_cnt = 0;

    bit m_act = 0;
    bit m_frame = 0;
    int m_y = 0;
    bit m_err = 0;
    int m_done = 0;

    always @(negedge clk) begin
        if (wr_en_up || wr_en_dn) begin
            got.push_back('{wr_addr, wr_data, wr_en_dn});
        end
        if (wr_en_up && wr_en_dn) both_cnt++;
        if (frame_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_vs();
        if (m_act) m_err = 1;
        m_act = 1;
        m_y = 0;
    endtask

    task automatic model_line(input int n);
        int neff;
        wr_t w;
        if (!m_act) return;
        neff = (n > 640) ? 640 : n;
        for (int k = 0; k < (neff + 3) / 4; k++) begin
            w.data = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < neff && px[4 * k + j] >= 8'd128) w.data[3 - j] = 1'b1;
            end
            w.addr = 17'(k + (m_y % 200) * 160 + (m_frame ? 38400 : 0));
            w.dn = (m_y >= 200);
            exp_q.push_back(w);
        end
        if (n < 640) m_err = 1;
        m_y++;
        if (m_y == 400) begin
            m_act = 0;
            m_done++;
            m_frame = ~m_frame;
        end
    endtask

    task automatic fill(input int n, input int kind);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 3);
            case (kind)
                0: px[i] = 8'd255;
                1: px[i] = (r == 0) ? 8'd127 : (r == 1) ? 8'd128 : 8'($urandom_range(0, 255));
                default: px[i] = 8'd0;
            endcase
        end
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vid_de = 1'b1;
            vid_luma = px[i];
        end
        @(negedge clk);
        vid_de = 1'b0;
        vid_luma = 8'd0;
        @(negedge clk);
        @(negedge clk);
        model_line(n);
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        vid_vs = 1'b1;
        @(negedge clk);
        vid_vs = 1'b0;
        @(negedge clk);
        model_vs();
    endtask

    task automatic compare_writes(input string name);
        int n;
        check({name, " count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s write %0d: got addr=%0d data=%h dn=%b expected addr=%0d data=%h dn=%b",
                         name, i, got[i].addr, got[i].data, got[i].dn,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].dn);
                break;
            end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic model_reset();
        m_act = 0;
        m_frame = 0;
        m_y = 0;
        m_err = 0;
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int idx;
        int n;
        tv[0] = '{32'hFF0000FF, 4'b1001};
        tv[1] = '{32'h807F00C8, 4'b1001};
        tv[2] = '{32'h7F808100, 4'b0110};
        tv[3] = '{32'h00000000, 4'b0000};
        tv[4] = '{32'hFFFFFFFF, 4'b1111};
        tv[5] = '{32'h80808080, 4'b1111};
        tv[6] = '{32'h7F7F7F7F, 4'b0000};
        tv[7] = '{32'h01FE7F80, 4'b0101};

        rst = 1'b1;
        en = 1'b1;
        vid_vs = 1'b0;
        vid_de = 1'b0;
        vid_luma = 8'd0;
        repeat (3) @(negedge clk);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset wr_en_up", wr_en_up, 0);
        check("reset wr_en_dn", wr_en_dn, 0);
        check("reset frame", frame, 0);
        check("reset frame_done", frame_done, 0);
        check("reset err_short", err_short, 0);
        rst = 1'b0;
        @(negedge clk);

        fill(8, 0);
        send_line(8);
        check("writes before vs", got.size(), 0);
        pulse_vs();
        check("err at start", err_short, 0);

        // Frame A: table lines, long line, short line, random remainder.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                vid_de = 1'b1;
                vid_luma = tv[i].lum[31 - 8 * j -: 8];
                px[j] = vid_luma;
                if (j == 3) check("tbl strobe early", wr_en_up, 0);
            end
            @(negedge clk);
            vid_de = 1'b0;
            check("tbl strobe", wr_en_up, 1);
            check("tbl data", wr_data, tv[i].nib);
            check("tbl addr", wr_addr, i * 160);
            @(negedge clk);
            model_line(4);
        end
        check("err after short", err_short, 1);

        fill(642, 1);
        send_line(642);
        idx = got.size();
        fill(6, 0);
        send_line(6);
        check("6px writes", got.size() - idx, 2);
        check("flush pad", (got.size() > 0) ? got[got.size() - 1].data : 4'hx, 4'b1100);
        check("flush addr", (got.size() > 0) ? got[got.size() - 1].addr : 17'h1ffff, 9 * 160 + 1);
        compare_writes("frameA head");

        for (int y = 10; y < 400; y++) begin
            n = (y == 198 || y == 199 || y == 200 || y == 399) ? 640 : $urandom_range(1, 24);
            fill(n, 1);
            send_line(n);
            if (y == 398) check("no early done", done_cnt, 0);
        end
        repeat (4) @(negedge clk);
        compare_writes("frameA body");
        check("frameA done", done_cnt, m_done);
        check("frameA frame", frame, m_frame);
        check("frameA err", err_short, m_err);

        fill(8, 0);
        send_line(8);
        compare_writes("after done ignored");

        // Frame B with a restart a few lines in.
        pulse_vs();
        check("frameB frame", frame, 1);
        fill(640, 1);
        send_line(640);
        for (int y = 1; y < 5; y++) begin
            fill(8, 1);
            send_line(8);
        end
        pulse_vs();
        check("restart frame", frame, 1);
        check("restart no done", done_cnt, 1);
        idx = got.size();
        for (int y = 0; y < 400; y++) begin
            n = (y == 0 || y == 399) ? 640 : $urandom_range(1, 16);
            fill(n, (y == 399) ? 0 : 1);
            send_line(n);
        end
        repeat (4) @(negedge clk);
        check("frameB first addr", (got.size() > idx) ? got[idx].addr : 17'h0, 38400);
        check("frameB last addr", (got.size() > 0) ? got[got.size() - 1].addr : 17'h0, 70399);
        compare_writes("frameB");
        check("frameB done", done_cnt, m_done);
        check("frameB frame back", frame, m_frame);

        // Restart with clean error flag, then enable gating.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("err cleared", err_short, 0);
        pulse_vs();
        for (int y = 0; y < 3; y++) begin
            fill(640, 1);
            send_line(640);
        end
        check("full lines no err", err_short, m_err);
        pulse_vs();
        check("vs restart err", err_short, 1);
        check("vs restart frame", frame, 0);
        check("vs restart done", done_cnt, 2);
        compare_writes("before restart");

        @(negedge clk); vid_de = 1'b1; vid_luma = 8'hFF;
        @(negedge clk); vid_luma = 8'h00;
        @(negedge clk); en = 1'b0; vid_luma = 8'hFF;
        repeat (2) @(negedge clk);
        @(negedge clk); en = 1'b1; vid_luma = 8'h00;
        @(negedge clk); vid_luma = 8'hFF;
        @(negedge clk); vid_de = 1'b0;
        check("en gate strobe", wr_en_up, 1);
        check("en gate data", wr_data, 4'b1001);
        check("en gate addr", wr_addr, 0);
        @(negedge clk);
        @(negedge clk);
        px[0] = 8'hFF; px[1] = 8'h00; px[2] = 8'h00; px[3] = 8'hFF;
        model_line(4);
        compare_writes("en gated line");

        // Run to line 250, then reset asynchronously mid-line.
        for (int y = 1; y < 250; y++) begin
            fill(4, 2);
            send_line(4);
        end
        compare_writes("to line 250");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vid_de = 1'b1;
            vid_luma = 8'hFF;
        end
        check("line250 dn", wr_en_dn, 1);
        check("line250 addr", wr_addr, 50 * 160);
        check("line250 err", err_short, 1);
        #2 rst = 1'b1;
        #1 check("async reset outs",
                 {wr_addr, wr_data, wr_en_up, wr_en_dn, frame, frame_done, err_short}, 0);
        @(negedge clk);
        vid_de = 1'b0;
        rst = 1'b0;
        model_reset();
        fill(8, 0);
        send_line(8);
        check("no write after reset", got.size(), 0);
        pulse_vs();
        fill(4, 0);
        send_line(4);
        compare_writes("after reset");
        check("strobe one-hot", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
